hilo_div_ctrl: RTL and testbench
================================

Name: hilo_div_ctrl

Overview:
- Multi-cycle sequencer for DIV/DIVU. Runs a radix-2 restoring divider over 32 iterations.
- Stalls the pipeline while it runs, then issues a single HI/LO write request (quotient to LO, remainder to HI).
- Sits beside the EX stage. Its write request is merged with the other HI/LO writers ahead of HILO.
- Supports cancellation on pipeline flush.

Parameters:
- WIDTH, 32: operand/result width. The iteration count equals WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-low
- start  in  1  divide request from EX (qualified by the DIV/DIVU decode)
- signed_op  in  1  1 = DIV (signed), 0 = DIVU
- dividend  in  WIDTH  srcLeft
- divisor  in  WIDTH  srcRight
- annul  in  1  flush; cancels any in-flight divide
- stall_req  out  1  pipeline stall request
- o_we  out  1  HI/LO write enable, one-cycle pulse
- o_hi  out  WIDTH  remainder
- o_lo  out  WIDTH  quotient
- busy  out  1  1 while not in IDLE

Behaviour:
- Reset (rst=0 at an edge): state to IDLE; count to 0; o_we, o_hi, o_lo to 0; internal quotient/remainder registers to 0. Reset overrides everything, including a divide in progress. No write is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and annul=0: latch the operands.
    - Divisor==0: next state DONE with quotient=all ones and remainder=dividend. This applies to both signed and unsigned.
    - Otherwise: latch |dividend| and |divisor| (absolute values only when signed_op=1). Record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend), both only when signed. Clear the partial remainder. count=0. Next state RUN.
  - start=1 and annul=1: ignored; stay in IDLE.
- RUN, each cycle:
  - Shift {rem, quot} left by 1, taking the next dividend MSB.
  - If rem >= |divisor|, subtract and set the quotient LSB.
  - Compare using a WIDTH+1-bit subtract.
  - count increments each cycle. On the cycle with count==WIDTH-1, next state is DONE.
  - In that transition, apply sign correction: negate the quotient if neg_q; negate the remainder if neg_r.
  - The magnitude of -2^31 is handled as unsigned 2^31. Therefore 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (two's-complement wrap), with no exception.
- DONE: o_we=1 for exactly this cycle, with o_hi/o_lo stable. Next state IDLE unconditionally.
- o_hi/o_lo hold their values after DONE until the next DONE. o_we=0 in every other state.
- stall_req:
  - Combinational.
  - 1 in IDLE when start=1, annul=0.
  - 1 throughout RUN.
  - 0 in DONE, so the instruction advances in the write cycle.
- Latency:
  - Start accepted at cycle 0; o_we at cycle WIDTH+1 (33).
  - Divide-by-zero: o_we at cycle 1.
- annul:
  - In RUN: next state IDLE; no o_we; stall_req drops the same cycle.
  - In DONE: o_we is forced to 0 for that cycle (write suppressed); next state IDLE.
- start while busy: ignored. Operands are latched only in IDLE.
- A back-to-back start in the cycle after DONE (state IDLE) is accepted normally.
- busy = (state != IDLE).

Test Plan:
- Unsigned 100/7: o_we high exactly once at cycle 33 with o_lo=14, o_hi=2. stall_req is high in cycles 0–32 and low at cycle 33.
- Signed -7/2 (0xFFFFFFF9/0x00000002): o_lo=0xFFFFFFFD, o_hi=0xFFFFFFFF.
- Signed 7/-2: o_lo=0xFFFFFFFD, o_hi=0x00000001.
- Divide-by-zero 5/0 (either signedness): o_we at cycle 1 with o_lo=0xFFFFFFFF, o_hi=5. stall_req is high only in cycle 0.
- Overflow case, signed 0x80000000/0xFFFFFFFF: o_lo=0x80000000, o_hi=0, o_we at cycle 33.
- Annul at cycle 10 of a run: no o_we ever; busy=0 at cycle 11. A fresh start at cycle 11 of 9/3 completes at cycle 44 with o_lo=3, o_hi=0.
- rst=0 asserted mid-RUN: next edge gives busy=0, o_we=0, o_hi=o_lo=0. A start during reset is ignored.
- start pulsed during RUN with different operands: the result reflects only the original operands.

Source files
------------

// File: rtl/hilo_div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer: a radix-2 restoring divider that stalls EX,
// then issues one HI/LO write (quotient to LO, remainder to HI).
module hilo_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             annul,
    output logic             stall_req,
    output logic             o_we,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quot_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             neg_q_r;
    logic             neg_r_r;

    logic             accept_s;
    logic             div_zero_s;
    logic             last_s;
    logic [WIDTH:0]   shifted_s;
    logic             ge_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] quot_next_s;

    // -2^(WIDTH-1) maps to unsigned 2^(WIDTH-1), which is what makes MIN/-1 wrap cleanly.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        if (is_signed && v[WIDTH-1]) begin
            return {WIDTH{1'b0}} - v;
        end else begin
            return v;
        end
    endfunction

    function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v,
                                                     input logic neg);
        if (neg) begin
            return {WIDTH{1'b0}} - v;
        end else begin
            return v;
        end
    endfunction

    assign accept_s    = start && !annul;
    assign div_zero_s  = (divisor == {WIDTH{1'b0}});
    assign last_s      = (count_r == CW'(WIDTH - 1));
    assign shifted_s   = {rem_r, quot_r[WIDTH-1]};
    assign ge_s        = (shifted_s >= {1'b0, dvs_r});
    assign rem_next_s  = ge_s ? (shifted_s[WIDTH-1:0] - dvs_r) : shifted_s[WIDTH-1:0];
    assign quot_next_s = {quot_r[WIDTH-2:0], ge_s};
    assign busy        = (state_r != IDLE);
    assign o_hi        = hi_r;
    assign o_lo        = lo_r;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode plus stall and write-enable outputs.
    always_comb begin
        state_s   = state_r;
        stall_req = 1'b0;
        o_we      = 1'b0;
        case (state_r)
            IDLE: begin
                stall_req = accept_s;
                if (accept_s) begin
                    state_s = div_zero_s ? DONE : RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                stall_req = !annul;
                if (annul) begin
                    state_s = IDLE;
                end else if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                o_we    = !annul;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Operand capture, shift/subtract iteration and result latching.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= {CW{1'b0}};
            rem_r   <= {WIDTH{1'b0}};
            quot_r  <= {WIDTH{1'b0}};
            dvs_r   <= {WIDTH{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s && div_zero_s) begin
                        lo_r    <= {WIDTH{1'b1}};
                        hi_r    <= dividend;
                        count_r <= {CW{1'b0}};
                    end else if (accept_s) begin
                        quot_r  <= magnitude(dividend, signed_op);
                        dvs_r   <= magnitude(divisor, signed_op);
                        rem_r   <= {WIDTH{1'b0}};
                        neg_q_r <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r_r <= signed_op && dividend[WIDTH-1];
                        count_r <= {CW{1'b0}};
                    end
                end
                RUN: begin
                    if (annul) begin
                        count_r <= {CW{1'b0}};
                    end else begin
                        rem_r   <= rem_next_s;
                        quot_r  <= quot_next_s;
                        count_r <= count_r + CW'(1);
                        if (last_s) begin
                            lo_r <= cond_negate(quot_next_s, neg_q_r);
                            hi_r <= cond_negate(rem_next_s, neg_r_r);
                        end
                    end
                end
                default: begin
                    count_r <= {CW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Self-checking bench for hilo_div_ctrl: directed corner cases plus random
// divides compared against plain 64-bit integer division.
module tb_hilo_div_ctrl;
    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        annul;
    logic        stall_req;
    logic        o_we;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic        busy;

    int total = 0;
    int bad   = 0;

    hilo_div_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor), .annul(annul),
        .stall_req(stall_req), .o_we(o_we), .o_hi(o_hi), .o_lo(o_lo), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: divide-by-zero rule, else truncating division on 64-bit integers.
    function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint na, nb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            if (s) begin
                na = longint'($signed(a));
                nb = longint'($signed(b));
            end else begin
                na = longint'({32'd0, a});
                nb = longint'({32'd0, b});
            end
            q = 32'(na / nb);
            r = 32'(na % nb);
        end
    endfunction

    // Cycle 0 presents the request; annul_cyc < 0 means no flush; poke re-pulses start mid-run.
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input int annul_cyc, input bit poke);
        logic [31:0] eq, er;
        int          lat, last;
        bit          live;
        ref_div(s, a, b, eq, er);
        lat  = (b == 32'd0) ? 1 : 33;
        last = (annul_cyc >= 0) ? annul_cyc + 1 : lat + 1;
        for (int c = 0; c <= last; c++) begin
            if (c > 0) @(posedge clk);
            #1;
            start     = (c == 0) || (poke && c == 5);
            signed_op = (c == 0) ? s : ~s;
            dividend  = (c == 0) ? a : (a ^ 32'h5A5A_0F0F);
            divisor   = (c == 0) ? b : (b + 32'd3);
            annul     = (c == annul_cyc);
            #1;
            live = (annul_cyc < 0) || (c < annul_cyc);
            chk($sformatf("stall c%0d", c), {31'd0, stall_req}, {31'd0, live && (c < lat)});
            chk($sformatf("we c%0d", c), {31'd0, o_we}, {31'd0, live && (c == lat)});
            chk($sformatf("busy c%0d", c), {31'd0, busy},
                {31'd0, (c >= 1) && (c <= lat) && ((annul_cyc < 0) || (c <= annul_cyc))});
            if (annul_cyc < 0 && c >= lat) begin
                chk($sformatf("lo %h/%h c%0d", a, b, c), o_lo, eq);
                chk($sformatf("hi %h/%h c%0d", a, b, c), o_hi, er);
            end
        end
        start = 1'b0;
        annul = 1'b0;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        rst = 1'b0; start = 1'b0; signed_op = 1'b0;
        dividend = 32'd0; divisor = 32'd0; annul = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst we", {31'd0, o_we}, 32'd0);
        chk("rst hi", o_hi, 32'd0);
        chk("rst lo", o_lo, 32'd0);
        chk("rst stall", {31'd0, stall_req}, 32'd0);
        rst = 1'b1;
        @(posedge clk);

        do_div(1'b0, 32'd100, 32'd7, -1, 1'b0);
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, -1, 1'b0);
        do_div(1'b0, 32'd5, 32'd0, -1, 1'b0);
        do_div(1'b1, 32'd5, 32'd0, -1, 1'b0);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
        do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
        do_div(1'b0, 32'd123456, 32'd789, 10, 1'b0);
        do_div(1'b0, 32'd9, 32'd3, -1, 1'b0);
        do_div(1'b1, 32'hDEAD_BEEF, 32'd17, -1, 1'b1);
        // Back-to-back start in the IDLE cycle right after DONE.
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, -1, 1'b0);

        for (int i = 0; i < 10; i++) begin
            rs = 1'($urandom_range(1, 0));
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(9, 1)) : $urandom;
            if (i % 2 == 1) rb = {{16{rb[15]}}, rb[15:0]};
            do_div(rs, ra, rb, -1, 1'b0);
        end

        // Reset mid-run, with start held during reset.
        @(posedge clk); #1;
        start = 1'b1; signed_op = 1'b0; dividend = 32'd50; divisor = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre-rst busy", {31'd0, busy}, 32'd1);
        rst = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        chk("mid-rst busy", {31'd0, busy}, 32'd0);
        chk("mid-rst we", {31'd0, o_we}, 32'd0);
        chk("mid-rst hi", o_hi, 32'd0);
        chk("mid-rst lo", o_lo, 32'd0);
        @(posedge clk); #1;
        chk("rst start ignored", {31'd0, busy}, 32'd0);
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        chk("post-rst busy", {31'd0, busy}, 32'd0);
        chk("post-rst lo", o_lo, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
